serial_tx: RTL and testbench

UART transmitter for the FTDI link: accepts bytes through a valid/ready handshake into a small FIFO and serialises them 8N1 on the TX line (FTDI_BD1), optionally gated by the FTDI CTS line (FTDI_BD2). It is the outbound counterpart of the `serial` receiver and runs in the same pixel-clock domain. It lets `sloader`/`torus` report state (generation counts, torus dumps) back to the host.

---
 rtl/serial_pkg.sv | 19 +
 rtl/serial_tx_fifo.sv | 63 ++++++
 rtl/serial_tx.sv | 176 +++++++++++++++++
 tb/tb_serial_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link blocks: transmitter state encoding,
// bit-period divisor calculation and frame length.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int FRAME_BITS = 10;

  // Rounded clocks-per-bit so the line rate error stays below half a cycle.
  function automatic int div_calc(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/serial_tx_fifo.sv
// Synchronous byte FIFO with registered pointers and occupancy count.
// Writes when full and reads when empty are ignored.
module serial_tx_fifo
  import serial_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_wr;
  logic          w_rd;

  assign full    = (r_count == FULL_CNT);
  assign empty   = (r_count == '0);
  assign count   = r_count;
  assign rd_data = r_mem[r_rd_ptr];
  assign w_wr    = wr_en && !full;
  assign w_rd    = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/serial_tx.sv
// 8N1 UART transmitter fed from a byte FIFO. Defining SERIAL_TX_CTS_EN adds
// a synchronised active-low clear-to-send gate checked only at frame start.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLK_HZ     = 74250000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk74,
  input  logic                          reset,
  input  logic [7:0]                    tx_byte,
  input  logic                          tbyte_valid,
  output logic                          tbyte_ready,
  input  logic                          cts_n,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = div_calc(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  tx_state_t   r_state;
  tx_state_t   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]  r_bit;
  logic [2:0]  w_bit_nxt;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_nxt;
  logic        r_tx;
  logic        r_busy;
  logic        r_ready_en;
  logic        w_line;
  logic        w_pop;
  logic        w_clear;
  logic        w_full;
  logic        w_empty;
  logic        w_bit_end;
  logic [7:0]  w_head;

`ifdef SERIAL_TX_CTS_EN
  logic r_cts_meta;
  logic r_cts_sync;

  always_ff @(posedge clk74) begin
    if (reset) begin
      r_cts_meta <= 1'b1;
      r_cts_sync <= 1'b1;
    end else begin
      r_cts_meta <= cts_n;
      r_cts_sync <= r_cts_meta;
    end
  end

  assign w_clear = ~r_cts_sync;
`else
  logic w_unused_cts;
  assign w_unused_cts = cts_n;
  assign w_clear      = 1'b1;
`endif

  assign tbyte_ready = r_ready_en && !w_full;
  assign tx          = r_tx;
  assign busy        = r_busy;
  assign w_bit_end   = (r_cnt == CNT_LAST);

  serial_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk74),
    .rst     (reset),
    .wr_en   (tbyte_valid && tbyte_ready),
    .wr_data (tx_byte),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .count   (fifo_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_pop       = 1'b0;
    w_line      = 1'b1;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty && w_clear) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        w_line = 1'b0;
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = 3'd0;
          w_state_nxt = DATA;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      DATA: begin
        w_line = r_shift[0];
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_nxt = r_bit + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      STOP: begin
        w_line = 1'b1;
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          // Chain straight into the next start bit so back-to-back frames abut.
          if (!w_empty && w_clear) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = START;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk74) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd0;
      r_shift <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Line and status are registered, so tx trails the FSM state by one cycle.
  always_ff @(posedge clk74) begin
    if (reset) begin
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_ready_en <= 1'b0;
    end else begin
      r_tx       <= w_line;
      r_busy     <= (r_state != IDLE) || !w_empty;
      r_ready_en <= 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx: frame-level reference model compared
// every cycle, directed scenarios with literal expectations, random traffic.
`timescale 1ns/1ps
module tb_serial_tx;

  localparam int DIV   = 10;
  localparam int FR    = 100;
  localparam int DEPTH = 4;

  logic       clk74 = 1'b0;
  logic       reset;
  logic [7:0] tx_byte;
  logic       tbyte_valid;
  logic       tbyte_ready;
  logic       cts_n;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;

  serial_tx #(
    .CLK_HZ     (1000),
    .BAUD       (100),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk74       (clk74),
    .reset       (reset),
    .tx_byte     (tx_byte),
    .tbyte_valid (tbyte_valid),
    .tbyte_ready (tbyte_ready),
    .cts_n       (cts_n),
    .tx          (tx),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk74 = ~clk74;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state: queued bytes plus the most recent frame start edge.
  logic [7:0] q[$];
  logic [7:0] fd;
  int         fs = 0;
  bit         fv = 0;
  logic       m_tx = 1'b1, m_busy = 1'b0, m_ready = 1'b0;
  logic       cts_s1 = 1'b1, cts_s2 = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return d[idx-1];
  endfunction

  task automatic model_step();
    bit active;
    bit clear;
    cyc++;
    if (reset) begin
      q.delete();
      fv = 0; m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b0;
      cts_s1 = 1'b1; cts_s2 = 1'b1;
    end else begin
      active = fv && (cyc > fs) && (cyc <= fs + FR);
      m_tx   = active ? frame_bit(fd, (cyc - fs - 1) / DIV) : 1'b1;
      m_busy = active || (q.size() > 0);
`ifdef SERIAL_TX_CTS_EN
      clear = (cts_s2 == 1'b0);
`else
      clear = 1'b1;
`endif
      if ((!active || cyc == fs + FR) && q.size() > 0 && clear) begin
        fd = q.pop_front();
        fs = cyc;
        fv = 1;
      end
      if (tbyte_valid && m_ready) q.push_back(tx_byte);
      m_ready = (q.size() < DEPTH);
      cts_s2  = cts_s1;
      cts_s1  = cts_n;
    end
  endtask

  initial forever begin
    @(posedge clk74);
    model_step();
  end

  initial forever begin
    @(negedge clk74);
    if (cyc > 0) begin
      chk("model_tx", tx, m_tx);
      chk("model_busy", busy, m_busy);
      chk("model_count", fifo_count, q.size());
      chk("model_ready", tbyte_ready, m_ready);
    end
  end

  task automatic tick();
    @(posedge clk74);
    #1;
  endtask

  task automatic wait_fall(output int fall);
    fall = -1;
    for (int i = 0; i < 400; i++) begin
      if (tx === 1'b0) begin
        fall = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(output int when);
    when = -1;
    for (int i = 0; i < 3000; i++) begin
      if (busy === 1'b0) begin
        when = cyc;
        break;
      end
      tick();
    end
  endtask

  task automatic put(input logic [7:0] b);
    tx_byte = b;
    tbyte_valid = 1'b1;
    tick();
    tbyte_valid = 1'b0;
  endtask

  int acc, fall, idle_at, peak, drop_edge, lows;
  logic [9:0]  exp_a5 = 10'b1101001010;
  logic [19:0] exp_pair = 20'b1_11111111_0_1_00000000_0;

  initial begin
    reset = 1'b1; tx_byte = 8'h00; tbyte_valid = 1'b0; cts_n = 1'b0;
    tick();
    chk("reset_ready", tbyte_ready, 1'b0);
    chk("reset_tx", tx, 1'b1);
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("post_reset_ready", tbyte_ready, 1'b1);
    chk("post_reset_busy", busy, 1'b0);
    chk("post_reset_count", fifo_count, 3'd0);

    // Single byte 0xA5.
    tick();
    put(8'hA5);
    acc = cyc;
    wait_fall(fall);
    chk("a5_latency", fall - acc, 2);
    for (int b = 0; b < 10; b++) begin
      while (cyc < fall + 5 + 10 * b) tick();
      chk("a5_bit", tx, exp_a5[b]);
    end
    wait_idle(idle_at);
    chk("a5_busy_fall", idle_at - fall, 100);

    // Back-to-back 0x00, 0xFF.
    tick();
    peak = 0;
    tx_byte = 8'h00; tbyte_valid = 1'b1; tick();
    if (fifo_count > peak) peak = fifo_count;
    tx_byte = 8'hFF; tick();
    if (fifo_count > peak) peak = fifo_count;
    tbyte_valid = 1'b0;
    wait_fall(fall);
    for (int j = 0; j < 200; j++) begin
      if (fifo_count > peak) peak = fifo_count;
      if (j % 10 == 5) chk("pair_bit", tx, exp_pair[j/10]);
      tick();
    end
    chk("pair_peak_count", peak, 1);
    wait_idle(idle_at);

    // Six bytes while the host holds off.
    cts_n = 1'b1;
    repeat (4) tick();
    for (int k = 0; k < 6; k++) begin
      tx_byte = 8'h10 + 8'(k); tbyte_valid = 1'b1; tick();
    end
    tbyte_valid = 1'b0;
`ifdef SERIAL_TX_CTS_EN
    chk("cts_full_count", fifo_count, 3'd4);
    chk("cts_full_ready", tbyte_ready, 1'b0);
    repeat (30) tick();
    chk("cts_hold_tx", tx, 1'b1);
    drop_edge = cyc;
    cts_n = 1'b0;
    wait_fall(fall);
    chk("cts_release_latency", fall - drop_edge, 4);
    wait_idle(idle_at);
    chk("cts_four_frames", idle_at - fall, 400);
`else
    cts_n = 1'b0;
    wait_idle(idle_at);
`endif

    // Raise cts_n mid-frame of 0x3C.
    tick();
    put(8'h3C);
    put(8'h99);
    wait_fall(fall);
    while (cyc < fall + 30) tick();
    cts_n = 1'b1;
    while (cyc < fall + 200) tick();
`ifdef SERIAL_TX_CTS_EN
    chk("cts_mid_waiting", fifo_count, 3'd1);
    chk("cts_mid_tx", tx, 1'b1);
`endif
    cts_n = 1'b0;
    wait_idle(idle_at);

    // Reset during data bit 3 of 0x81 with two bytes queued.
    tick();
    put(8'h81);
    put(8'h42);
    put(8'h24);
    wait_fall(fall);
    while (cyc < fall + 45) tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_count", fifo_count, 3'd0);
    chk("rst_mid_busy", busy, 1'b0);
    reset = 1'b0;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      if (tx !== 1'b1) lows++;
      tick();
    end
    chk("rst_no_frames", lows, 0);

`ifndef SERIAL_TX_CTS_EN
    // cts_n is ignored in this build.
    cts_n = 1'b1;
    put(8'h55);
    acc = cyc;
    wait_fall(fall);
    chk("nocts_latency", fall - acc, 2);
    wait_idle(idle_at);
    cts_n = 1'b0;
`endif

    // Random traffic, host flow control and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      tbyte_valid = ($urandom_range(0, 3) == 0);
      tx_byte     = 8'($urandom);
      if ($urandom_range(0, 199) == 0) cts_n = ~cts_n;
      reset = ($urandom_range(0, 1499) == 0);
      tick();
    end
    reset = 1'b0; tbyte_valid = 1'b0; cts_n = 1'b0;
    tick();
    wait_idle(idle_at);
    chk("final_idle", (idle_at >= 0), 1'b1);
    tick();
    chk("final_count", fifo_count, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
